// File: rtl/rr_issue_arbiter32.sv
// 32-requester round-robin issue-select arbiter with a registered one-hot grant and a valid/ready output.
// Optional build macro RR_ARB_PERF_EN adds o_stall_cnt, a saturating count of stalled-grant cycles.
module rr_issue_arbiter32 #(
    parameter logic [4:0] RESET_PTR = 5'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_req,
    input  logic        i_flush,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_grant,
    output logic [4:0]  o_grant_idx
`ifdef RR_ARB_PERF_EN
    ,
    output logic [15:0] o_stall_cnt
`endif
);

    logic [4:0]  ptr_r;
    logic        valid_r;
    logic [31:0] grant_r;
    logic [4:0]  grant_idx_r;

    logic        any_req_s;
    logic        load_s;
    logic [4:0]  sel_idx_s;
    logic [31:0] sel_s;

    // First set request bit, searching upward from ptr and wrapping past 31.
    function automatic logic [4:0] rr_pick(input logic [31:0] req, input logic [4:0] ptr);
        logic [4:0] idx;
        logic [4:0] cand;
        logic       found;
        idx   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cand = ptr + 5'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // Combinational selection and load decision.
    always_comb begin
        any_req_s = |i_req;
        load_s    = !valid_r || i_ready;
        sel_idx_s = rr_pick(i_req, ptr_r);
        if (any_req_s) begin
            sel_s = 32'd1 << sel_idx_s;
        end else begin
            sel_s = 32'd0;
        end
    end

    // Grant register and priority pointer; a stalled grant ignores i_req entirely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r       <= RESET_PTR;
            valid_r     <= 1'b0;
            grant_r     <= 32'd0;
            grant_idx_r <= 5'd0;
        end else if (i_flush) begin
            valid_r     <= 1'b0;
            grant_r     <= 32'd0;
            grant_idx_r <= 5'd0;
        end else if (load_s) begin
            valid_r <= any_req_s;
            grant_r <= sel_s;
            if (any_req_s) begin
                grant_idx_r <= sel_idx_s;
                ptr_r       <= sel_idx_s + 5'd1;
            end else begin
                grant_idx_r <= 5'd0;
            end
        end
    end

    assign o_valid     = valid_r;
    assign o_grant     = grant_r;
    assign o_grant_idx = grant_idx_r;

`ifdef RR_ARB_PERF_EN
    logic [15:0] stall_cnt_r;

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if (valid_r && !i_ready && !i_flush && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_rr_issue_arbiter32.sv
// Directed, table-driven bench for rr_issue_arbiter32 (RESET_PTR=0) plus hand-written reset sequences.
module tb_rr_issue_arbiter32;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_req;
    logic        i_flush;
    logic        i_ready;
    logic        o_valid;
    logic [31:0] o_grant;
    logic [4:0]  o_grant_idx;
`ifdef RR_ARB_PERF_EN
    logic [15:0] o_stall_cnt;
`endif

    rr_issue_arbiter32 #(.RESET_PTR(5'd0)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_flush     (i_flush),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_grant     (o_grant),
        .o_grant_idx (o_grant_idx)
`ifdef RR_ARB_PERF_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] req;
        logic        rdy;
        logic        flush;
        logic        ev;
        logic [4:0]  eidx;
    } vec_t;

    vec_t tbl [0:39];
    int   nvec;
    int   errors;
    int   checks;
    int   exp_stall;
    logic prev_ev;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function void add(input logic [31:0] req, input logic rdy, input logic flush,
                      input logic ev, input logic [4:0] eidx);
        tbl[nvec].req   = req;
        tbl[nvec].rdy   = rdy;
        tbl[nvec].flush = flush;
        tbl[nvec].ev    = ev;
        tbl[nvec].eidx  = eidx;
        nvec++;
    endfunction

    task automatic check_out(input string tag, input int id, input logic ev, input logic [4:0] eidx);
        logic [31:0] eg;
        logic [4:0]  ei;
        eg = ev ? (32'd1 << eidx) : 32'd0;
        ei = ev ? eidx : 5'd0;
        checks++;
        if (o_valid !== ev || o_grant !== eg || o_grant_idx !== ei) begin
            errors++;
            $display("FAIL %s%0d: got valid=%0b grant=%h idx=%0d, want valid=%0b grant=%h idx=%0d",
                     tag, id, o_valid, o_grant, o_grant_idx, ev, eg, ei);
        end
        checks++;
        if (!(o_grant == 32'd0 || $onehot(o_grant)) ||
            (o_valid && o_grant != (32'd1 << o_grant_idx)) ||
            (!o_valid && (o_grant != 32'd0 || o_grant_idx != 5'd0))) begin
            errors++;
            $display("FAIL invariant_%s%0d: got valid=%0b grant=%h idx=%0d, want consistent one-hot/zero",
                     tag, id, o_valid, o_grant, o_grant_idx);
        end
    endtask

`ifdef RR_ARB_PERF_EN
    task automatic check_stall(input string tag, input int id);
        checks++;
        if (o_stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL stall_cnt_%s%0d: got %0d, want %0d", tag, id, o_stall_cnt, exp_stall);
        end
    endtask
`endif

    initial begin
        errors    = 0;
        checks    = 0;
        nvec      = 0;
        exp_stall = 0;
        i_rst_n   = 1'b0;
        i_req     = 32'd0;
        i_flush   = 1'b0;
        i_ready   = 1'b1;

        // alternation between bits 0 and 2
        add(32'h0000_0005, 1'b1, 1'b0, 1'b1, 5'd0);
        add(32'h0000_0005, 1'b1, 1'b0, 1'b1, 5'd2);
        add(32'h0000_0005, 1'b1, 1'b0, 1'b1, 5'd0);
        add(32'h0000_0005, 1'b1, 1'b0, 1'b1, 5'd2);
        // wrap: bit 30 leaves ptr at 31
        add(32'h4000_0000, 1'b1, 1'b0, 1'b1, 5'd30);
        add(32'h8000_0001, 1'b1, 1'b0, 1'b1, 5'd31);
        add(32'h8000_0001, 1'b1, 1'b0, 1'b1, 5'd0);
        add(32'h8000_0001, 1'b1, 1'b0, 1'b1, 5'd31);
        // stall holding idx 3 while req changes
        add(32'h0000_0008, 1'b1, 1'b0, 1'b1, 5'd3);
        for (int k = 0; k < 4; k++) add(32'h0000_0100, 1'b0, 1'b0, 1'b1, 5'd3);
        add(32'h0000_0100, 1'b1, 1'b0, 1'b1, 5'd8);
        add(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd9);
        // ready ignored while invalid
        add(32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0);
        add(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0);
        add(32'h0000_0001, 1'b0, 1'b0, 1'b1, 5'd0);
        add(32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0);
        // flush during stall, then flush overriding a load
        add(32'h0000_0080, 1'b1, 1'b0, 1'b1, 5'd7);
        add(32'h0000_0080, 1'b0, 1'b1, 1'b0, 5'd0);
        add(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd8);
        add(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd0);
        add(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd9);
        // single requester every cycle, then ptr = idx+1
        for (int k = 0; k < 3; k++) add(32'h0000_0010, 1'b1, 1'b0, 1'b1, 5'd4);
        add(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd5);
        add(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd6);

        // reset state while held
        @(negedge i_clk);
        @(negedge i_clk);
        check_out("reset_held", 0, 1'b0, 5'd0);
`ifdef RR_ARB_PERF_EN
        check_stall("reset_held", 0);
`endif
        #2 i_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            check_out("idle", k, 1'b0, 5'd0);
        end

        prev_ev = 1'b0;
        for (int v = 0; v < nvec; v++) begin
            i_req   = tbl[v].req;
            i_ready = tbl[v].rdy;
            i_flush = tbl[v].flush;
            if (prev_ev && !tbl[v].rdy && !tbl[v].flush) exp_stall++;
            @(negedge i_clk);
            check_out("vec", v, tbl[v].ev, tbl[v].eidx);
`ifdef RR_ARB_PERF_EN
            check_stall("vec", v);
`endif
            prev_ev = tbl[v].ev;
        end
        i_flush = 1'b0;

        // async reset pulse between edges during streaming
        i_req   = 32'hFFFF_FFFF;
        i_ready = 1'b1;
        #2 i_rst_n = 1'b0;
        exp_stall = 0;
        #1;
        check_out("async_rst", 0, 1'b0, 5'd0);
`ifdef RR_ARB_PERF_EN
        check_stall("async_rst", 0);
`endif
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        check_out("post_rst", 0, 1'b1, 5'd0);
        @(negedge i_clk);
        check_out("post_rst", 1, 1'b1, 5'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
